// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter sequencing states (3-bit encoding shared with the core build).
    typedef enum logic [2:0] {
        StArb   = 3'd0,
        StData  = 3'd1,
        StFetch = 3'd2,
        StGap   = 3'd3,
        StRel   = 3'd4
    } arb_state_e;

    // Value loaded into a destination register when its transfer is abandoned.
    localparam logic [31:0] ZeroData = 32'h0000_0000;

endpackage

// File: rtl/arb_wdog.sv
// Transfer watchdog: counts un-acknowledged request cycles and flags expiry
// on the cycle the count would reach TIMEOUT. TIMEOUT=0 disables expiry.
module arb_wdog #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LastCnt = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [TO_W-1:0] MaxCnt  = '1;

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next count: clear on a new request, otherwise saturating increment while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // An ack in the same cycle suppresses inc_i, so a late ack still wins.
        expired_o = (TIMEOUT != 0) && inc_i && !clr_i && (cnt_q == LastCnt);
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Each core step runs an optional data transfer then a fetch, holding the core
// paused until both results are latched, then releases it for one cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr_i,
    output logic [31:0] ins_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_we_i,
    input  logic [31:0] d_dout_i,
    output logic [31:0] d_din_o,
    output logic        pause_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_dout_o,
    input  logic [31:0] mem_din_i,
    input  logic        mem_ack_i,
    output logic        bus_err_o,
    output logic [31:0] err_addr_o
);

    arb_state_e  state_q, state_d;
    logic        pause_q, pause_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_dout_q, mem_dout_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] d_din_q, d_din_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [31:0] hold_iaddr_q, hold_iaddr_d;
    logic [3:0]  hold_we_q, hold_we_d;
    logic        gap_data_q, gap_data_d;  // ST_GAP entered from a data timeout

    logic xfer_done;
    logic wd_clr;
    logic wd_inc;
    logic wd_expired;

    assign xfer_done = mem_req_q & mem_ack_i;
    assign wd_inc    = mem_req_q & ~mem_ack_i;

    arb_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .inc_i     (wd_inc),
        .expired_o (wd_expired)
    );

    // Next-state and next-output logic for the step sequencer.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_dout_d   = mem_dout_q;
        ins_d        = ins_q;
        d_din_d      = d_din_q;
        bus_err_d    = bus_err_q;
        err_addr_d   = err_addr_q;
        hold_iaddr_d = hold_iaddr_q;
        hold_we_d    = hold_we_q;
        gap_data_d   = gap_data_q;
        wd_clr       = 1'b0;

        unique case (state_q)
            StArb: begin
                hold_iaddr_d = i_addr_i;
                hold_we_d    = d_we_i;
                mem_req_d    = 1'b1;
                wd_clr       = 1'b1;
                if (d_req_i) begin
                    mem_addr_d = d_addr_i;
                    mem_we_d   = d_we_i;
                    mem_dout_d = d_dout_i;
                    state_d    = StData;
                end else begin
                    mem_addr_d = i_addr_i;
                    mem_we_d   = 4'b0000;
                    state_d    = StFetch;
                end
            end
            StData: begin
                if (xfer_done) begin
                    if (hold_we_q == 4'b0000) begin
                        d_din_d = mem_din_i;
                    end
                    // Fetch follows back-to-back with req held high.
                    mem_addr_d = hold_iaddr_q;
                    mem_we_d   = 4'b0000;
                    wd_clr     = 1'b1;
                    state_d    = StFetch;
                end else if (wd_expired) begin
                    if (hold_we_q == 4'b0000) begin
                        d_din_d = ZeroData;
                    end
                    bus_err_d = 1'b1;
                    if (!bus_err_q) begin
                        err_addr_d = mem_addr_q;
                    end
                    mem_req_d  = 1'b0;
                    gap_data_d = 1'b1;
                    state_d    = StGap;
                end
            end
            StFetch: begin
                if (xfer_done) begin
                    ins_d     = mem_din_i;
                    mem_req_d = 1'b0;
                    mem_we_d  = 4'b0000;
                    state_d   = StRel;
                end else if (wd_expired) begin
                    ins_d     = ZeroData;
                    bus_err_d = 1'b1;
                    if (!bus_err_q) begin
                        err_addr_d = mem_addr_q;
                    end
                    mem_req_d  = 1'b0;
                    gap_data_d = 1'b0;
                    state_d    = StGap;
                end
            end
            StGap: begin
                // One idle cycle so a late ack from the abandoned transfer is dropped.
                if (gap_data_q) begin
                    mem_addr_d = hold_iaddr_q;
                    mem_we_d   = 4'b0000;
                    mem_req_d  = 1'b1;
                    wd_clr     = 1'b1;
                    state_d    = StFetch;
                end else begin
                    state_d = StRel;
                end
            end
            StRel: begin
                state_d = StArb;
            end
            default: begin
                state_d = StArb;
            end
        endcase

        pause_d = (state_d != StRel);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StArb;
            pause_q      <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= '0;
            mem_dout_q   <= '0;
            ins_q        <= '0;
            d_din_q      <= '0;
            bus_err_q    <= 1'b0;
            err_addr_q   <= '0;
            hold_iaddr_q <= '0;
            hold_we_q    <= '0;
            gap_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pause_q      <= pause_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_dout_q   <= mem_dout_d;
            ins_q        <= ins_d;
            d_din_q      <= d_din_d;
            bus_err_q    <= bus_err_d;
            err_addr_q   <= err_addr_d;
            hold_iaddr_q <= hold_iaddr_d;
            hold_we_q    <= hold_we_d;
            gap_data_q   <= gap_data_d;
        end
    end

    assign pause_o    = pause_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_we_o   = mem_we_q;
    assign mem_dout_o = mem_dout_q;
    assign ins_o      = ins_q;
    assign d_din_o    = d_din_q;
    assign bus_err_o  = bus_err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus randomized steps, each checked
// against a step-level model (results, error capture, step latency, bus traffic).
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr_i;
    logic [31:0] ins_o;
    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic [3:0]  d_we_i;
    logic [31:0] d_dout_i;
    logic [31:0] d_din_o;
    logic        pause_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_dout_o;
    logic [31:0] mem_din_i;
    logic        mem_ack_i;
    logic        bus_err_o;
    logic [31:0] err_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural model state.
    logic [31:0] m_din;
    logic [31:0] m_ins;
    logic        m_err;
    logic [31:0] m_err_addr;

    mem_port_arbiter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr_i   (i_addr_i),
        .ins_o      (ins_o),
        .d_req_i    (d_req_i),
        .d_addr_i   (d_addr_i),
        .d_we_i     (d_we_i),
        .d_dout_i   (d_dout_i),
        .d_din_o    (d_din_o),
        .pause_o    (pause_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_we_o   (mem_we_o),
        .mem_dout_o (mem_dout_o),
        .mem_din_i  (mem_din_i),
        .mem_ack_i  (mem_ack_i),
        .bus_err_o  (bus_err_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Cycles a transfer occupies: w wait states, or TIMEOUT cycles plus the gap.
    function automatic int cost(input int w);
        return (w < TIMEOUT) ? w + 1 : TIMEOUT + 1;
    endfunction

    task automatic model_reset();
        m_din      = 32'h0;
        m_ins      = 32'h0;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
    endtask

    // Runs one core step starting at a negedge inside the ARB cycle; returns at
    // the negedge inside the release cycle. The bench plays the memory.
    task automatic run_step(input logic dreq, input logic [31:0] daddr, input logic [3:0] dwe,
                            input logic [31:0] ddout, input logic [31:0] iaddr,
                            input int wd, input int wf,
                            input logic [31:0] rdd, input logic [31:0] rdf);
        logic [31:0] x_addr[2];
        logic [3:0]  x_we[2];
        logic [31:0] x_dout[2];
        logic        x_isdata[2];
        int          x_w[2];
        logic [31:0] x_rd[2];
        int nx, idx, reqc, cyc, exp_lat;
        bit done;

        d_req_i   = dreq;
        d_addr_i  = daddr;
        d_we_i    = dwe;
        d_dout_i  = ddout;
        i_addr_i  = iaddr;
        mem_ack_i = 1'($urandom % 2);
        mem_din_i = $urandom;

        nx = 0;
        if (dreq) begin
            x_addr[0] = daddr; x_we[0] = dwe; x_dout[0] = ddout; x_isdata[0] = 1'b1;
            x_w[0] = wd; x_rd[0] = rdd;
            nx = 1;
        end
        x_addr[nx] = iaddr; x_we[nx] = 4'b0000; x_dout[nx] = 32'h0; x_isdata[nx] = 1'b0;
        x_w[nx] = wf; x_rd[nx] = rdf;
        nx++;

        // Expected results from the step rules.
        if (dreq) begin
            if (wd < TIMEOUT) begin
                if (dwe == 4'b0000) m_din = rdd;
            end else begin
                if (dwe == 4'b0000) m_din = 32'h0;
                if (!m_err) begin m_err = 1'b1; m_err_addr = daddr; end
            end
        end
        if (wf < TIMEOUT) begin
            m_ins = rdf;
        end else begin
            m_ins = 32'h0;
            if (!m_err) begin m_err = 1'b1; m_err_addr = iaddr; end
        end
        exp_lat = 2 + (dreq ? cost(wd) : 0) + cost(wf);

        check("arb_pause", 32'(pause_o), 32'd1);
        check("arb_req", 32'(mem_req_o), 32'd0);

        cyc = 1; idx = 0; reqc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!pause_o) begin
                done = 1;
            end else if (mem_req_o) begin
                if (idx >= nx) begin
                    check("extra_req", 32'(mem_req_o), 32'd0);
                    mem_ack_i = 1'b0;
                end else begin
                    check("xfer_addr", mem_addr_o, x_addr[idx]);
                    check("xfer_we", 32'(mem_we_o), 32'(x_we[idx]));
                    if (x_isdata[idx]) check("xfer_dout", mem_dout_o, x_dout[idx]);
                    reqc++;
                    if (reqc == x_w[idx] + 1) begin
                        mem_ack_i = 1'b1;
                        mem_din_i = x_rd[idx];
                        idx++;
                        reqc = 0;
                    end else begin
                        mem_ack_i = 1'b0;
                        mem_din_i = $urandom;
                        if (reqc == TIMEOUT) begin
                            idx++;
                            reqc = 0;
                        end
                    end
                end
            end else begin
                // Idle or gap cycle: stray acks with junk data must be ignored.
                mem_ack_i = (($urandom % 4) != 0);
                mem_din_i = $urandom;
            end
        end

        check("step_bound", 32'(done), 32'd1);
        if (done) begin
            check("latency", 32'(cyc), 32'(exp_lat));
            check("xfer_count", 32'(idx), 32'(nx));
            check("ins", ins_o, m_ins);
            check("d_din", d_din_o, m_din);
            check("bus_err", 32'(bus_err_o), 32'(m_err));
            check("err_addr", err_addr_o, m_err_addr);
        end
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom % 8);
        if (r < 4) return 0;
        if (r < 6) return int'($urandom_range(1, 3));
        if (r == 6) return TIMEOUT - 1;
        return TIMEOUT + int'($urandom % 3);
    endfunction

    initial begin
        logic        rq;
        logic [3:0]  we;
        int          wd;

        rst       = 1'b0;
        i_addr_i  = 32'h0;
        d_req_i   = 1'b0;
        d_addr_i  = 32'h0;
        d_we_i    = 4'h0;
        d_dout_i  = 32'h0;
        mem_din_i = 32'h0;
        mem_ack_i = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_pause", 32'(pause_o), 32'd1);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_dout", mem_dout_o, 32'h0);
        check("rst_ins", ins_o, 32'h0);
        check("rst_din", d_din_o, 32'h0);
        check("rst_err", 32'(bus_err_o), 32'd0);
        check("rst_err_addr", err_addr_o, 32'h0);
        rst = 1'b1;

        // Fetch-only, zero wait.
        run_step(1'b0, 32'h0, 4'h0, 32'h0, 32'h100, 0, 0, 32'h0, 32'h3C01_0001);
        @(negedge clk);
        // Load then fetch, zero wait, back-to-back.
        run_step(1'b1, 32'h2000, 4'h0, 32'h0, 32'h104, 0, 0, 32'hDEAD_BEEF, 32'h8C22_0004);
        @(negedge clk);
        // Store with two wait states; load data must be unchanged.
        run_step(1'b1, 32'h2004, 4'b0011, 32'h0000_ABCD, 32'h108, 2, 0, 32'h1111_1111,
                 32'hAC22_0008);
        @(negedge clk);
        // Ack exactly on the timeout cycle wins for both transfers.
        run_step(1'b1, 32'h2008, 4'h0, 32'h0, 32'h10C, TIMEOUT - 1, TIMEOUT - 1,
                 32'h5555_AAAA, 32'h2402_0007);
        @(negedge clk);
        // Data read never acked: abandoned, error captured, fetch still completes.
        run_step(1'b1, 32'h3000, 4'h0, 32'h0, 32'h110, 99, 1, 32'hFFFF_FFFF, 32'h0800_0040);
        @(negedge clk);
        // Fetch timeout after an error: err_addr keeps the first address.
        run_step(1'b0, 32'h0, 4'h0, 32'h0, 32'h114, 0, 99, 32'h0, 32'h1234_5678);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rq = 1'($urandom % 2);
            we = (($urandom % 3) == 0) ? 4'h0 : 4'($urandom);
            wd = rand_wait();
            if (we != 4'h0 && wd >= TIMEOUT) wd = TIMEOUT - 1;
            run_step(rq, $urandom & 32'hFFFF_FFFC, we, $urandom, $urandom & 32'hFFFF_FFFC,
                     wd, rand_wait(), $urandom, $urandom);
        end

        // Reset while a data read is waiting on its first wait state.
        @(negedge clk);
        d_req_i   = 1'b1;
        d_addr_i  = 32'h4000;
        d_we_i    = 4'h0;
        i_addr_i  = 32'h500;
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("midrst_req_before", 32'(mem_req_o), 32'd1);
        check("midrst_addr_before", mem_addr_o, 32'h4000);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_req", 32'(mem_req_o), 32'd0);
        check("midrst_pause", 32'(pause_o), 32'd1);
        check("midrst_err", 32'(bus_err_o), 32'd0);
        check("midrst_ins", ins_o, 32'h0);
        rst = 1'b1;
        model_reset();
        run_step(1'b1, 32'h4000, 4'h0, 32'h0, 32'h500, 1, 0, 32'hCAFE_F00D, 32'h2108_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got timeout, expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port external memory between the core's instruction fetch and its data load/store.
- Sits between the mips core's zz_* memory interface and the board memory bus.
- Sequences at most one data transfer, then one fetch, per core step.
- Holds the core frozen through pause_o until both results are latched, then releases it for exactly one cycle.

Parameters:
- TIMEOUT, 16: maximum cycles a request waits for mem_ack_i. 0 disables the timeout.
- TO_W, 5: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic is clocked on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_addr_i  in  32  fetch address (core zz_pc_o).
- ins_o  out  32  latched instruction to core (zz_ins_i).
- d_req_i  in  1  core requests a data access this step.
- d_addr_i  in  32  data address.
- d_we_i  in  4  byte write enables; 0000 means a read.
- d_dout_i  in  32  store data.
- d_din_o  out  32  latched load data to core.
- pause_o  out  1  core stall (core pause).
- mem_req_o  out  1  memory request valid.
- mem_addr_o  out  32  memory address.
- mem_we_o  out  4  memory byte write enables.
- mem_dout_o  out  32  memory write data.
- mem_din_i  in  32  memory read data; valid when mem_ack_i=1.
- mem_ack_i  in  1  transfer complete.
- bus_err_o  out  1  sticky timeout flag.
- err_addr_o  out  32  address of the first timed-out transfer.

Behaviour:
- All outputs are registered.
- Reset applies on any clk edge with rst=0 and takes precedence over everything, including mid-transfer:
  - state=ST_ARB, pause_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_dout_o=0.
  - ins_o=0, d_din_o=0, bus_err_o=0, err_addr_o=0, timeout count=0.
- States: ST_ARB, ST_DATA, ST_FETCH, ST_GAP, ST_REL. pause_o=1 in every state except ST_REL.
- ST_ARB:
  - Samples the core inputs into holding registers; the core is paused, so they are stable.
  - If d_req_i=1: load mem_addr_o=d_addr_i, mem_we_o=d_we_i, mem_dout_o=d_dout_i, mem_req_o=1, then go to ST_DATA.
  - Otherwise: load mem_addr_o=i_addr_i, mem_we_o=0, mem_req_o=1, then go to ST_FETCH.
- ST_DATA, on a cycle with mem_ack_i=1:
  - If the access is a read (held we=0), d_din_o<=mem_din_i; on a write, d_din_o is unchanged.
  - Load the fetch request (addr=held i_addr, we=0) and keep mem_req_o=1 (back-to-back), then go to ST_FETCH.
- ST_FETCH, on a cycle with mem_ack_i=1: ins_o<=mem_din_i, mem_req_o<=0, mem_we_o<=0, then go to ST_REL.
- ST_REL:
  - pause_o=0 for exactly one cycle; the core advances.
  - Next state is ST_ARB with pause_o=1.
- Handshake rules:
  - Every cycle with mem_req_o=1 and mem_ack_i=1 completes one transfer.
  - Address, we and dout are stable while req is held without ack.
  - mem_ack_i is ignored while mem_req_o=0.
- Timeout:
  - The counter clears on every new request and increments each cycle with req=1 and ack=0.
  - When it reaches TIMEOUT, the transfer is abandoned:
    - the destination register is loaded with 32'h0;
    - bus_err_o<=1;
    - err_addr_o captures mem_addr_o, only if bus_err_o was 0;
    - mem_req_o<=0 and the next state is ST_GAP.
  - ST_GAP is one idle cycle with req=0. A late ack there is dropped. Then sequencing resumes: ST_FETCH if the data access timed out, ST_REL if the fetch timed out.
  - bus_err_o stays set until reset.
- An ack on the same cycle the count reaches TIMEOUT wins; the transfer completes normally.
- Latency, zero-wait memory:
  - fetch-only step = 3 cycles (ARB, FETCH, REL);
  - data+fetch step = 4 cycles.
  - Each memory wait state adds 1 cycle.

Decomposition:
- State encodings (3-bit) and the zero-data constant go in mips789_defs.v as `defines, shared with the core build.
- One sub-module, arb_wdog: the timeout counter with clr/inc inputs, an expired output and the TIMEOUT/TO_W parameters.
- The FSM and the holding registers stay in mem_port_arbiter.

Test Plan:
- Reset held 3 cycles, then released, with d_req_i=0 and i_addr_i=0x100:
  - mem_req_o=1, addr=0x100 on the cycle after ARB;
  - ack with din=0x3C010001 -> ins_o=0x3C010001 and pause_o=0 exactly one cycle, 3 cycles after ARB.
- Load: d_req_i=1, d_addr_i=0x2000, d_we_i=0, zero-wait memory returning 0xDEADBEEF then 0x8C220004:
  - d_din_o=0xDEADBEEF, ins_o=0x8C220004;
  - mem_req_o stays high across both transfers;
  - pause_o low once, 4 cycles after ARB.
- Store: d_we_i=0011, d_dout_i=0x0000ABCD, 2 wait states:
  - mem_we_o=0011 held 3 cycles;
  - d_din_o unchanged;
  - fetch issued with we=0.
- Timeout, TIMEOUT=4, no ack on a data read of 0x3000:
  - after 4 cycles req drops, d_din_o=0, bus_err_o=1, err_addr_o=0x3000;
  - an ack in ST_GAP is ignored;
  - the fetch then completes normally.
- Ack arriving on the exact cycle the count hits TIMEOUT -> normal completion, bus_err_o stays 0.
- rst=0 asserted mid-ST_DATA with 1 wait state pending -> next edge: mem_req_o=0, pause_o=1, state ST_ARB; a fresh step completes normally after release.
